// File: rtl/prog_sqr_wav_pkg.sv
// Shared types and default sizing for the programmable square-wave generator.
package prog_sqr_wav_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF} sqr_state_t;

   localparam int DEF_N        = 4;
   localparam int DEF_CH       = 4;
   localparam int DEF_PRESCALE = 5;
endpackage

// File: rtl/sqr_wav_chan.sv
// One square-wave channel: IDLE/ON/OFF sequencer, interval counter,
// active and pending m/n registers, and the end-of-period pulse.
module sqr_wav_chan
   import prog_sqr_wav_pkg::*;
#(
   parameter int N = DEF_N
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         tick,
   input  logic         en,
   input  logic         load,
   input  logic [N-1:0] m,
   input  logic [N-1:0] n,
   output logic         sqr,
   output logic         period_done
);

   sqr_state_t   state, state_nxt;
   logic [N-1:0] cnt, cnt_nxt;
   logic [N-1:0] m_act, m_act_nxt, n_act, n_act_nxt;
   logic [N-1:0] m_pend, n_pend, m_sel, n_sel;
   logic         pend_flag, flag_nxt;
   logic         m_last, n_last, boundary;

   // Zero lengths are guarded explicitly so the N-bit "minus one" never wraps.
   assign m_last   = (m_act != '0) && (cnt == m_act - N'(1));
   assign n_last   = (n_act == '0) || (cnt == n_act - N'(1));
   assign boundary = tick && (((state == ST_ON) && m_last && (n_act == '0)) ||
                              ((state == ST_OFF) && n_last));

   // m=n=0 re-evaluates pending values every tick but is not a real period.
   assign period_done = boundary && ((m_act != '0) || (n_act != '0));

   assign m_sel = pend_flag ? m_pend : m_act;
   assign n_sel = pend_flag ? n_pend : n_act;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      m_act_nxt = m_act;
      n_act_nxt = n_act;
      flag_nxt  = pend_flag;
      if (!en) begin
         state_nxt = ST_IDLE;
         cnt_nxt   = '0;
      end else if (state == ST_IDLE) begin
         m_act_nxt = m_pend;
         n_act_nxt = n_pend;
         flag_nxt  = 1'b0;
         cnt_nxt   = '0;
         state_nxt = (m_pend != '0) ? ST_ON : ST_OFF;
      end else if (boundary) begin
         m_act_nxt = m_sel;
         n_act_nxt = n_sel;
         flag_nxt  = 1'b0;
         cnt_nxt   = '0;
         state_nxt = (m_sel != '0) ? ST_ON : ST_OFF;
      end else if (tick) begin
         if ((state == ST_ON) && m_last) begin
            cnt_nxt   = '0;
            state_nxt = ST_OFF;
         end else begin
            cnt_nxt = cnt + 1'b1;
         end
      end
      // A load coinciding with a boundary keeps the new values queued.
      if (load) flag_nxt = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         m_act     <= '0;
         n_act     <= '0;
         m_pend    <= '0;
         n_pend    <= '0;
         pend_flag <= 1'b0;
         sqr       <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         m_act     <= m_act_nxt;
         n_act     <= n_act_nxt;
         pend_flag <= flag_nxt;
         sqr       <= (state_nxt == ST_ON);
         if (load) begin
            m_pend <= m;
            n_pend <= n;
         end
      end
   end

endmodule

// File: rtl/multi_ch_sqr_wav_gen.sv
// Multi-channel square-wave generator: shared tick prescaler feeding CH
// independent channels that all capture m/n on the common load strobe.
module multi_ch_sqr_wav_gen
   import prog_sqr_wav_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int CH       = DEF_CH,
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [CH-1:0]   en_i,
   input  logic            load_i,
   input  logic [CH*N-1:0] m_i,
   input  logic [CH*N-1:0] n_i,
   output logic [CH-1:0]   sqr_wav_o,
   output logic [CH-1:0]   period_done_o
);

   localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] pre_cnt;
   logic          tick;

   // With PRESCALE=1 the counter sits at zero and every clock is a tick.
   assign tick = (pre_cnt == PRE_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  pre_cnt <= '0;
      else if (tick) pre_cnt <= '0;
      else           pre_cnt <= pre_cnt + 1'b1;
   end

   for (genvar k = 0; k < CH; k++) begin : g_chan
      sqr_wav_chan #(.N(N)) u_chan (
         .clk         (clk),
         .reset_n     (reset_n),
         .tick        (tick),
         .en          (en_i[k]),
         .load        (load_i),
         .m           (m_i[k*N +: N]),
         .n           (n_i[k*N +: N]),
         .sqr         (sqr_wav_o[k]),
         .period_done (period_done_o[k])
      );
   end

endmodule

// File: tb/tb_multi_ch_sqr_wav_gen.sv
// Bench for multi_ch_sqr_wav_gen: PRESCALE=1 and PRESCALE=5 instances share
// stimulus and are checked every cycle against a phase-countdown model.
module tb_multi_ch_sqr_wav_gen;
   localparam int N  = 4;
   localparam int CH = 4;
   localparam int M_IDLE = 0, M_HIGH = 1, M_LOW = 2;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [CH-1:0]   en = '0;
   logic            load = 1'b0;
   logic [CH*N-1:0] m_in = '0, n_in = '0;
   logic [CH-1:0]   sqr1, done1, sqr5, done5;

   int vectors = 0, miscompares = 0;

   // Model: per instance/channel phase, ticks left in phase, active/pending m,n.
   int pres[2];
   int pc[2];
   int mode[2][CH], left[2][CH], am[2][CH], an[2][CH], pm[2][CH], pn[2][CH], pf[2][CH];
   int hi_cnt[2][CH], pl_cnt[2][CH];

   always #5 clk = ~clk;

   multi_ch_sqr_wav_gen #(.N(N), .CH(CH), .PRESCALE(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .en_i(en), .load_i(load), .m_i(m_in), .n_i(n_in),
      .sqr_wav_o(sqr1), .period_done_o(done1));

   multi_ch_sqr_wav_gen #(.N(N), .CH(CH), .PRESCALE(5)) dut5 (
      .clk(clk), .reset_n(reset_n), .en_i(en), .load_i(load), .m_i(m_in), .n_i(n_in),
      .sqr_wav_o(sqr5), .period_done_o(done5));

   function automatic logic [CH-1:0] pred_out(int i);
      logic [CH-1:0] r;
      for (int k = 0; k < CH; k++) r[k] = (mode[i][k] == M_HIGH);
      return r;
   endfunction

   function automatic logic [CH-1:0] pred_done(int i);
      logic [CH-1:0] r;
      logic tk;
      tk = (pc[i] == pres[i] - 1);
      for (int k = 0; k < CH; k++)
         r[k] = tk && (left[i][k] == 1) &&
                ((mode[i][k] == M_HIGH && an[i][k] == 0) ||
                 (mode[i][k] == M_LOW && (am[i][k] != 0 || an[i][k] != 0)));
      return r;
   endfunction

   task automatic check_v(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic check_i(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         pc[i] = 0;
         for (int k = 0; k < CH; k++) begin
            mode[i][k] = M_IDLE; left[i][k] = 0; am[i][k] = 0; an[i][k] = 0;
            pm[i][k] = 0; pn[i][k] = 0; pf[i][k] = 0;
         end
      end
   endtask

   task automatic start_period(input int i, input int k);
      if (am[i][k] > 0) begin
         mode[i][k] = M_HIGH; left[i][k] = am[i][k];
      end else if (an[i][k] > 0) begin
         mode[i][k] = M_LOW;  left[i][k] = an[i][k];
      end else begin
         mode[i][k] = M_LOW;  left[i][k] = 1;
      end
   endtask

   task automatic model_step(input int i);
      logic tk;
      tk = (pc[i] == pres[i] - 1);
      for (int k = 0; k < CH; k++) begin
         if (!en[k]) begin
            mode[i][k] = M_IDLE;
         end else if (mode[i][k] == M_IDLE) begin
            am[i][k] = pm[i][k]; an[i][k] = pn[i][k]; pf[i][k] = 0;
            start_period(i, k);
         end else if (tk) begin
            left[i][k]--;
            if (left[i][k] == 0) begin
               if (mode[i][k] == M_HIGH && an[i][k] != 0) begin
                  mode[i][k] = M_LOW; left[i][k] = an[i][k];
               end else begin
                  if (pf[i][k] != 0) begin
                     am[i][k] = pm[i][k]; an[i][k] = pn[i][k]; pf[i][k] = 0;
                  end
                  start_period(i, k);
               end
            end
         end
         if (load) begin
            pm[i][k] = int'(m_in[k*N +: N]);
            pn[i][k] = int'(n_in[k*N +: N]);
            pf[i][k] = 1;
         end
      end
      pc[i] = (pc[i] + 1) % pres[i];
   endtask

   task automatic clear_win();
      for (int i = 0; i < 2; i++)
         for (int k = 0; k < CH; k++) begin
            hi_cnt[i][k] = 0; pl_cnt[i][k] = 0;
         end
   endtask

   // One clock: advance the model at the edge, compare at the falling edge.
   task automatic cycle();
      logic [CH-1:0] o, d;
      @(posedge clk);
      model_step(0);
      model_step(1);
      @(negedge clk);
      check_v("p1 sqr_wav_o", sqr1, pred_out(0));
      check_v("p1 period_done_o", done1, pred_done(0));
      check_v("p5 sqr_wav_o", sqr5, pred_out(1));
      check_v("p5 period_done_o", done5, pred_done(1));
      for (int i = 0; i < 2; i++) begin
         o = pred_out(i);
         d = pred_done(i);
         for (int k = 0; k < CH; k++) begin
            hi_cnt[i][k] += int'(o[k]);
            pl_cnt[i][k] += int'(d[k]);
         end
      end
   endtask

   task automatic set_mn(input int k, input int mv, input int nv);
      m_in[k*N +: N] = N'(mv);
      n_in[k*N +: N] = N'(nv);
   endtask

   initial begin
      int pat_o[10];
      int pat_d[10];
      logic [CH-1:0] tmp;
      int sum;

      pat_o = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0};
      pat_d = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      pres[0] = 1;
      pres[1] = 5;
      model_reset();
      clear_win();

      #12;
      check_v("reset sqr p1", sqr1, '0);
      check_v("reset done p1", done1, '0);
      check_v("reset sqr p5", sqr5, '0);
      check_v("reset done p5", done5, '0);
      @(negedge clk);
      reset_n = 1'b1;

      // Four distinct channel shapes, loaded while disabled.
      set_mn(0, 3, 2); set_mn(1, 0, 5); set_mn(2, 2, 3); set_mn(3, 5, 0);
      load = 1'b1;
      cycle();
      load = 1'b0;
      en = '1;
      cycle();
      for (int t = 0; t < 10; t++) begin
         tmp = pred_out(0);
         check_i("pin p1 ch0 out", int'(tmp[0]), pat_o[t]);
         tmp = pred_done(0);
         check_i("pin p1 ch0 done", int'(tmp[0]), pat_d[t]);
         cycle();
      end

      for (int t = 0; t < 30; t++) cycle();
      clear_win();
      for (int t = 0; t < 150; t++) cycle();
      check_i("win p1 ch0 high", hi_cnt[0][0], 90);  check_i("win p1 ch0 pulses", pl_cnt[0][0], 30);
      check_i("win p1 ch1 high", hi_cnt[0][1], 0);   check_i("win p1 ch1 pulses", pl_cnt[0][1], 30);
      check_i("win p1 ch2 high", hi_cnt[0][2], 60);  check_i("win p1 ch2 pulses", pl_cnt[0][2], 30);
      check_i("win p1 ch3 high", hi_cnt[0][3], 150); check_i("win p1 ch3 pulses", pl_cnt[0][3], 30);
      check_i("win p5 ch0 high", hi_cnt[1][0], 90);  check_i("win p5 ch0 pulses", pl_cnt[1][0], 6);
      check_i("win p5 ch1 high", hi_cnt[1][1], 0);   check_i("win p5 ch1 pulses", pl_cnt[1][1], 6);
      check_i("win p5 ch2 high", hi_cnt[1][2], 60);  check_i("win p5 ch2 pulses", pl_cnt[1][2], 6);
      check_i("win p5 ch3 high", hi_cnt[1][3], 150); check_i("win p5 ch3 pulses", pl_cnt[1][3], 6);

      // Reload ch0 to 1/4 while it is in its ON phase.
      for (int t = 0; t < 10; t++) begin
         tmp = pred_out(0);
         if (tmp[0]) break;
         cycle();
      end
      set_mn(0, 1, 4);
      load = 1'b1;
      cycle();
      load = 1'b0;
      for (int t = 0; t < 60; t++) cycle();
      clear_win();
      for (int t = 0; t < 50; t++) cycle();
      check_i("reload p1 ch0 high", hi_cnt[0][0], 10); check_i("reload p1 ch0 pulses", pl_cnt[0][0], 10);
      check_i("reload p5 ch0 high", hi_cnt[1][0], 10); check_i("reload p5 ch0 pulses", pl_cnt[1][0], 2);

      // Drop enable for a cycle, then resume.
      en[0] = 1'b0;
      cycle();
      tmp = pred_out(0);
      check_i("disabled p1 ch0 out", int'(tmp[0]), 0);
      en[0] = 1'b1;
      for (int t = 0; t < 20; t++) cycle();

      // Asynchronous reset between edges while ch3 is held high.
      #2 reset_n = 1'b0;
      #1;
      check_v("async reset sqr p1", sqr1, '0);
      check_v("async reset done p1", done1, '0);
      check_v("async reset sqr p5", sqr5, '0);
      check_v("async reset done p5", done5, '0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      clear_win();
      for (int t = 0; t < 20; t++) cycle();
      sum = 0;
      for (int i = 0; i < 2; i++)
         for (int k = 0; k < CH; k++) sum += hi_cnt[i][k] + pl_cnt[i][k];
      check_i("post-reset zero m/n activity", sum, 0);

      // Randomized enables, loads and m/n values with frequent zeros.
      for (int t = 0; t < 3000; t++) begin
         for (int k = 0; k < CH; k++)
            if ($urandom_range(49) == 0) en[k] = ~en[k];
         load = ($urandom_range(24) == 0);
         if (load)
            for (int k = 0; k < CH; k++)
               set_mn(k, ($urandom_range(3) == 0) ? 0 : int'($urandom_range(15)),
                         ($urandom_range(3) == 0) ? 0 : int'($urandom_range(15)));
         cycle();
      end
      load = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
